// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: op encodings, FSM states
// and a helper producing the most negative signed value at a given width.
package div_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'd0;
    localparam logic [1:0] DIV_OP_DIVU = 2'd1;
    localparam logic [1:0] DIV_OP_REM  = 2'd2;
    localparam logic [1:0] DIV_OP_REMU = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Most negative two's-complement value of an xlen-bit word (xlen <= 64).
    function automatic logic [63:0] div_min(input int unsigned xlen);
        return 64'(1) << (xlen - 1);
    endfunction

endpackage

// File: rtl/div_lzc.sv
// Leading-zero counter.
//   value : word to inspect
//   count : number of leading zeros; an all-zero word gives XLEN
module div_lzc #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]       value,
    output logic [$clog2(XLEN):0] count
);

    localparam int unsigned CW = $clog2(XLEN) + 1;

    // Scan upwards so the highest set bit is the last one to write count.
    always_comb begin
        count = CW'(XLEN);
        for (int unsigned i = 0; i < XLEN; i++) begin
            if (value[i]) begin
                count = CW'(XLEN - 1 - i);
            end
        end
    end

endmodule

// File: rtl/div_iter_unit.sv
// Handshaked restoring divider for DIV/DIVU/REM/REMU with ROB-tag pass-through,
// result hold under backpressure and flush.
//   clk, rst_n (sync, active-low), flush
//   in_valid/in_ready, in_op, in_dividend, in_divisor, in_tag : request side
//   out_valid/out_ready, out_result, out_tag                   : result side
//   busy : unit is not idle
module div_iter_unit
    import div_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TAG_W       = 6,
    parameter int unsigned EARLY_START = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_dividend,
    input  logic [XLEN-1:0]  in_divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned   CW      = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_VAL = XLEN'(div_min(XLEN));

    div_state_e       state;
    logic [CW-1:0]    cnt;
    logic [XLEN-1:0]  quo;      // dividend bits shift out the top, quotient bits in at the bottom
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  dvs;
    logic             neg_q;
    logic             neg_r;
    logic             is_rem;
    logic [TAG_W-1:0] tag_q;

    // Request decode: magnitudes, special cases, iteration count.
    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic [CW-1:0]   lz;
    logic [CW-1:0]   n_iter;
    logic [XLEN-1:0] a_pre;
    logic            accept;

    // |MIN| = 2^(XLEN-1) still fits an XLEN-bit unsigned magnitude.
    assign is_signed = (in_op == DIV_OP_DIV) || (in_op == DIV_OP_REM);
    assign a_neg     = is_signed && in_dividend[XLEN-1];
    assign b_neg     = is_signed && in_divisor[XLEN-1];
    assign a_mag     = a_neg ? -in_dividend : in_dividend;
    assign b_mag     = b_neg ? -in_divisor  : in_divisor;
    assign div_zero  = (in_divisor == '0);
    assign overflow  = is_signed && (in_dividend == MIN_VAL) && (in_divisor == '1);
    assign special   = div_zero || overflow || (in_dividend == '0);

    always_comb begin
        special_res = '0;
        if (in_op[1]) begin
            if (div_zero) special_res = in_dividend;
        end else begin
            if (div_zero)      special_res = '1;
            else if (overflow) special_res = MIN_VAL;
        end
    end

    div_lzc #(.XLEN(XLEN)) u_lzc (
        .value (a_mag),
        .count (lz)
    );

    assign n_iter = (EARLY_START != 0) ? (CW'(XLEN) - lz) : CW'(XLEN);
    assign a_pre  = (EARLY_START != 0) ? (a_mag << lz) : a_mag;

    assign in_ready = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept   = in_valid && in_ready && !flush;

    // One restoring step: subtract when the shifted partial remainder covers the divisor.
    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quo_nxt;
    logic [XLEN-1:0] final_res;

    assign shifted  = {rem, quo[XLEN-1]};
    assign ge       = (shifted >= {1'b0, dvs});
    assign rem_nxt  = ge ? XLEN'(shifted - {1'b0, dvs}) : shifted[XLEN-1:0];
    assign quo_nxt  = {quo[XLEN-2:0], ge};
    assign final_res = is_rem ? (neg_r ? -rem_nxt : rem_nxt)
                              : (neg_q ? -quo_nxt : quo_nxt);

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            quo        <= '0;
            rem        <= '0;
            dvs        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            is_rem     <= 1'b0;
            tag_q      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            busy       <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                CALC: begin
                    quo <= quo_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out_result <= final_res;
                        out_tag    <= tag_q;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase

            // Accept overrides the DONE->IDLE exit for back-to-back requests.
            if (accept) begin
                busy   <= 1'b1;
                tag_q  <= in_tag;
                is_rem <= in_op[1];
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                if (special) begin
                    state      <= DONE;
                    out_valid  <= 1'b1;
                    out_result <= special_res;
                    out_tag    <= in_tag;
                end else begin
                    state <= CALC;
                    quo   <= a_pre;
                    rem   <= '0;
                    dvs   <= b_mag;
                    cnt   <= n_iter;
                end
            end
        end
    end

endmodule
